ram_arbiter: RTL

Two-port round-robin arbiter that shares one single-port synchronous RAM between two requesters: port A (the Simplez CPU) and port B (the serial loader/monitor). It accepts requests with a combinational valid/grant handshake and drives the RAM chip-select, read/write, address and write-data lines from registers. It returns read data with a fixed latency and a per-port valid strobe. It sits between the requesters and the memory instance.

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 53 +++++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the two-port RAM arbiter: port identifiers, the RAM
// read/write mode encoding and the read-tracking tag carried down the
// response pipeline.
// Ports: none (package).
package ram_arb_pkg;

  // Port identifiers; also the meaning of the round-robin pointer.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // RAM mode line encoding (mem_rw).
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // One stage of the read-response tracker.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  // Requesters say 1 = write; the RAM wants 1 = read.
  function automatic logic rw_of_we(input logic we);
    return we ? RW_WRITE : RW_READ;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. Grants are purely combinational from
// req, the priority pointer and rst; the pointer flips to the losing side
// after every accepted transfer.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req[1:0]   request vector, bit 0 = port A, bit 1 = port B
//   accept     a granted request is transferring at this edge
//   gnt[1:0]   one-hot (or zero) grant vector
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  // A lone requester always wins; on contention the pointer decides.
  // Nothing is granted while reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio_q == PORT_A) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After a transfer the pointer moves to whichever port did not win.
  always_comb begin
    prio_d = prio_q;
    if (accept && (gnt != 2'b00)) begin
      prio_d = gnt[0] ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PORT_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port synchronous RAM between port A (CPU) and port B
// (serial loader/monitor). Accepted requests are registered onto the mem_*
// lines one cycle later; read responses come back two cycles after the
// accept edge with a per-port valid strobe.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata      port A request channel
//   a_gnt                          port A combinational grant
//   a_rdata/a_rvalid               port A read response
//   b_*                            same set for port B
//   mem_cs/mem_rw/mem_addr/mem_din registered RAM control and write data
//   mem_dout                       RAM registered read data
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,

  output logic          mem_cs,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  logic [1:0]    req_vec;
  logic [1:0]    gnt_vec;
  logic          accept;
  logic          win_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          mem_cs_q,   mem_cs_d;
  logic          mem_rw_q,   mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q,  mem_din_d;
  rd_tag_t       rd1_q, rd1_d;
  rd_tag_t       rd2_q, rd2_d;

  assign req_vec = {b_req, a_req};

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .gnt    (gnt_vec)
  );

  assign a_gnt = gnt_vec[0];
  assign b_gnt = gnt_vec[1];

  // The winning port's fields are steered onto a single request.
  always_comb begin
    accept    = |(req_vec & gnt_vec);
    win_port  = gnt_vec[1] ? PORT_B : PORT_A;
    sel_we    = gnt_vec[1] ? b_we    : a_we;
    sel_addr  = gnt_vec[1] ? b_addr  : a_addr;
    sel_wdata = gnt_vec[1] ? b_wdata : a_wdata;
  end

  // RAM lines capture the accepted access; when idle only chip select drops
  // and the rest hold. A read also enters the two-stage response tracker,
  // whose second stage lines up with mem_dout.
  always_comb begin
    mem_cs_d   = accept;
    mem_rw_d   = mem_rw_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (accept) begin
      mem_rw_d   = rw_of_we(sel_we);
      mem_addr_d = sel_addr;
      mem_din_d  = sel_wdata;
    end
    rd1_d.valid = accept && !sel_we;
    rd1_d.port  = win_port;
    rd2_d       = rd1_q;
  end

  // Reset flushes outstanding read strobes; an access already on the mem_*
  // lines is still executed by the RAM at the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cs_q   <= 1'b0;
      mem_rw_q   <= RW_READ;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
    end else begin
      mem_cs_q   <= mem_cs_d;
      mem_rw_q   <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
    end
  end

  assign mem_cs   = mem_cs_q;
  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

  assign a_rdata  = mem_dout;
  assign b_rdata  = mem_dout;
  assign a_rvalid = rd2_q.valid && (rd2_q.port == PORT_A);
  assign b_rvalid = rd2_q.valid && (rd2_q.port == PORT_B);

endmodule
